player_entity_controller: RTL and testbench
===========================================

PLAYER_ENTITY_CONTROLLER -- requirements
Module: player_entity_controller

Interface
REQ-001 SHALL have parameter ENTITY_ID, default 4'h1, entity ID driven on entity_out[13:10] when enabled.
REQ-002 SHALL have parameter START_LOC, default 8'h58, reset tile location {row[7:4], col[3:0]}.
REQ-003 SHALL have parameter MOVE_PERIOD, default 8, frames between repeated moves while a direction is held (legal range 1..255).
REQ-004 SHALL have port clk  input  1  pixel clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-006 SHALL have port frame_tick  input  1  one-cycle pulse per frame at start of vertical blanking.
REQ-007 SHALL have port enable  input  1  high = entity active and movable.
REQ-008 SHALL have ports btn_up, btn_right, btn_down, btn_left  input  1 each  raw asynchronous buttons, active-high.
REQ-009 SHALL have port entity_out  output  14  {ID[13:10], orientation[9:8], location[7:0]} for the frame buffer controller.
REQ-010 SHALL have port moved  output  1  one-cycle pulse when location or orientation was committed.

Function
REQ-011 SHALL pass each button through a two-flop synchronizer before any use.
REQ-012 SHALL resolve simultaneous buttons by priority up > right > down > left; lower-priority buttons are ignored.
REQ-013 SHALL encode orientation 2'b00 up, 2'b01 right, 2'b10 down, 2'b11 left.
REQ-014 SHALL treat the grid as 16 columns (0..15) x 12 rows (0..11); row values 12..15 never produced.
REQ-015 SHALL implement FSM states IDLE, MOVE, HOLD; MOVE lasts exactly one cycle.
REQ-016 IDLE: on frame_tick with a synchronized direction held -> MOVE; otherwise stay.
REQ-017 MOVE: latch direction into orientation, update location one tile in that direction, clear frame counter -> HOLD.
REQ-018 HOLD: on frame_tick with no direction held -> IDLE; with a direction held, increment frame counter; when counter reaches MOVE_PERIOD-1 -> MOVE.
REQ-019 SHALL sample direction for MOVE at the frame_tick cycle; button changes after that cycle do not affect the commit.
REQ-020 Latency: frame_tick sampled at edge N -> MOVE during cycle N+1 -> new entity_out and moved=1 visible in cycle N+2 only.
REQ-021 SHALL update entity_out only as a result of MOVE or enable changes; location never changes during active video.
REQ-022 Edge, no wrap: move beyond col 0/15 or row 0/11 leaves location unchanged but still updates orientation and pulses moved.
REQ-023 enable low: FSM forced to IDLE, frame counter cleared, frame_tick ignored, entity_out[13:10]=4'hF (unused channel), orientation and location retained and still driven on [9:0].
REQ-024 enable rising: entity_out[13:10] returns to ENTITY_ID next cycle; no move until a subsequent frame_tick.
REQ-025 frame_tick asserted during MOVE SHALL be ignored.

Reset
REQ-026 On rst_n low, asynchronously: FSM=IDLE, frame counter=0, synchronizers=0, orientation=2'b00, location=START_LOC, moved=0.
REQ-027 entity_out in reset SHALL be {ENTITY_ID, 2'b00, START_LOC}; reset mid-MOVE or mid-HOLD discards pending moves.
REQ-028 Release of rst_n SHALL be followed by normal operation from the first clock edge; no frame_tick needed to exit reset.

Configuration
REQ-029 Macro PLAYER_WRAP_EN defined: edges wrap -- col 15 right -> 0, col 0 left -> 15, row 11 down -> 0, row 0 up -> 11.
REQ-030 Macro PLAYER_WRAP_EN undefined: edges clamp per REQ-022.

Verification
REQ-031 Reset, no input -> entity_out = 14'h0458 (ID 1, up, loc 8'h58), moved=0.
REQ-032 Hold btn_right from reset, pulse frame_tick -> two cycles later loc 8'h59, orientation 01, moved one cycle; with MOVE_PERIOD=8, next move after 8 further ticks (loc 8'h5A).
REQ-033 Hold btn_up and btn_left together at loc 8'h58, one tick -> loc 8'h48, orientation 00 (priority).
REQ-034 At loc 8'hB5 hold btn_down, one tick -> without PLAYER_WRAP_EN loc 8'hB5, orientation 10, moved=1; with PLAYER_WRAP_EN loc 8'h05.
REQ-035 enable=0 with btn_left held, 3 ticks -> entity_out[13:10]=4'hF, location unchanged, moved never pulses; re-enable -> ID 4'h1.
REQ-036 Assert rst_n low asynchronously in HOLD after two moves -> entity_out = 14'h0458 immediately, FSM IDLE.

Source files
------------

// File: rtl/player_entity_controller.sv
// Player entity: synchronized buttons -> frame-paced tile moves on a 16x12 grid.
// Define PLAYER_WRAP_EN to wrap at grid edges instead of clamping.
`timescale 1ns/1ps
module player_entity_controller #(
  parameter logic [3:0]  ENTITY_ID   = 4'h1,
  parameter logic [7:0]  START_LOC   = 8'h58,
  parameter int unsigned MOVE_PERIOD = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        enable,
  input  logic        btn_up,
  input  logic        btn_right,
  input  logic        btn_down,
  input  logic        btn_left,
  output logic [13:0] entity_out,
  output logic        moved
);

`ifdef PLAYER_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif

  localparam logic [7:0] LAST_CNT = 8'(MOVE_PERIOD - 1);
  localparam logic [3:0] ROW_LAST = 4'd11;
  localparam logic [3:0] COL_LAST = 4'd15;
  localparam logic [3:0] ID_OFF   = 4'hF;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    HOLD
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [7:0] cnt;
  logic [7:0] cnt_n;
  logic [1:0] pend_dir;
  logic [1:0] pend_n;
  logic [1:0] orient;
  logic [7:0] loc;
  logic [3:0] id_q;
  logic       commit;

  logic [3:0] btn_raw;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic       dir_held;
  logic [1:0] dir_sel;

  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] row_n;
  logic [3:0] col_n;

  assign btn_raw = {btn_up, btn_right, btn_down, btn_left};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Buttons may overlap, so this is a priority encoder.
  always_comb begin
    dir_held = |sync2;
    dir_sel  = DIR_UP;
    priority case (1'b1)
      sync2[3]: dir_sel = DIR_UP;
      sync2[2]: dir_sel = DIR_RIGHT;
      sync2[1]: dir_sel = DIR_DOWN;
      sync2[0]: dir_sel = DIR_LEFT;
      default:  dir_sel = DIR_UP;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend_dir;
    commit  = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (frame_tick && dir_held) begin
            state_n = MOVE;
            pend_n  = dir_sel;
          end
        end
        MOVE: begin
          commit  = 1'b1;
          cnt_n   = '0;
          state_n = HOLD;
        end
        HOLD: begin
          if (frame_tick) begin
            if (!dir_held) begin
              state_n = IDLE;
            end else if (cnt == LAST_CNT) begin
              state_n = MOVE;
              pend_n  = dir_sel;
            end else begin
              cnt_n = cnt + 8'd1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    row   = loc[7:4];
    col   = loc[3:0];
    row_n = row;
    col_n = col;
    unique case (pend_dir)
      DIR_UP: begin
        if (row != 4'd0)  row_n = row - 4'd1;
        else if (WRAP)    row_n = ROW_LAST;
      end
      DIR_RIGHT: begin
        if (col != COL_LAST) col_n = col + 4'd1;
        else if (WRAP)       col_n = 4'd0;
      end
      DIR_DOWN: begin
        if (row < ROW_LAST) row_n = row + 4'd1;
        else if (WRAP)      row_n = 4'd0;
      end
      DIR_LEFT: begin
        if (col != 4'd0) col_n = col - 4'd1;
        else if (WRAP)   col_n = COL_LAST;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      pend_dir <= DIR_UP;
      orient   <= DIR_UP;
      loc      <= START_LOC;
      moved    <= 1'b0;
      id_q     <= ENTITY_ID;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pend_dir <= pend_n;
      moved    <= commit;
      id_q     <= enable ? ENTITY_ID : ID_OFF;
      if (commit) begin
        orient <= pend_dir;
        loc    <= {row_n, col_n};
      end
    end
  end

  assign entity_out = {id_q, orient, loc};

endmodule

// File: tb/tb_player_entity_controller.sv
// Directed bench for player_entity_controller.
// Expected entity words are queued at each tick and popped when moved fires.
`timescale 1ns/1ps
module tb_player_entity_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        frame_tick = 1'b0;
  logic        enable = 1'b1;
  logic        btn_up = 1'b0;
  logic        btn_right = 1'b0;
  logic        btn_down = 1'b0;
  logic        btn_left = 1'b0;
  logic [13:0] entity_out;
  logic        moved;

  int vectors = 0;
  int errors  = 0;

  logic [13:0] exp_q[$];
  logic [7:0]  exp_loc = 8'h58;
  logic [1:0]  exp_ori = 2'b00;
  logic [3:0]  exp_id  = 4'h1;

  player_entity_controller dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .enable    (enable),
    .btn_up    (btn_up),
    .btn_right (btn_right),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .entity_out(entity_out),
    .moved     (moved)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [13:0] obs,
                       input logic [13:0] want);
    vectors++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && moved) begin
      if (exp_q.size() == 0)
        check("moved_unexpected", {13'd0, moved}, 14'd0);
      else
        check("entity_on_move", entity_out, exp_q.pop_front());
    end
  end

  function automatic logic [1:0] prio(input logic [3:0] b);
    if (b[3]) return 2'd0;
    if (b[2]) return 2'd1;
    if (b[1]) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [7:0] step(input logic [7:0] l,
                                      input logic [1:0] d);
    int r = int'(l[7:4]);
    int c = int'(l[3:0]);
    case (d)
      2'd0: r = r - 1;
      2'd1: c = c + 1;
      2'd2: r = r + 1;
      default: c = c - 1;
    endcase
`ifdef PLAYER_WRAP_EN
    if (r < 0)  r = 11;
    if (r > 11) r = 0;
    if (c < 0)  c = 15;
    if (c > 15) c = 0;
`else
    if (r < 0)  r = 0;
    if (r > 11) r = 11;
    if (c < 0)  c = 0;
    if (c > 15) c = 15;
`endif
    return {4'(r), 4'(c)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btn_up, btn_right, btn_down, btn_left} = b;
  endtask

  task automatic tick(input logic expect_move, input string tag);
    logic [13:0] pre;
    pre = entity_out;
    frame_tick = 1'b1;
    if (expect_move) begin
      exp_ori = prio({btn_up, btn_right, btn_down, btn_left});
      exp_loc = step(exp_loc, exp_ori);
      exp_q.push_back({exp_id, exp_ori, exp_loc});
    end
    @(posedge clk);
    #1 frame_tick = 1'b0;
    @(negedge clk);
    check({tag, "_n1_moved"}, {13'd0, moved}, 14'd0);
    check({tag, "_n1_hold"}, entity_out, pre);
    @(negedge clk);
    check({tag, "_n2_moved"}, {13'd0, moved}, {13'd0, expect_move});
    check({tag, "_n2_ent"}, entity_out, {exp_id, exp_ori, exp_loc});
    @(posedge clk);
    #1;
  endtask

  task automatic do_move(input logic [3:0] b, input string tag);
    set_btn(b);
    cyc(3);
    tick(1'b1, tag);
    set_btn(4'b0000);
    cyc(3);
    tick(1'b0, {tag, "_rel"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ent", entity_out, 14'h0458);
    check("reset_moved", {13'd0, moved}, 14'd0);
    rst_n = 1'b1;
    cyc(1);

    tick(1'b0, "idle_nobtn");

    set_btn(4'b0100);
    cyc(3);
    tick(1'b1, "right1");
    check("right1_val", entity_out, 14'h0559);
    for (int i = 0; i < 7; i++) tick(1'b0, "hold_wait");
    tick(1'b1, "right2");
    check("right2_val", entity_out, 14'h055A);

    #3 rst_n = 1'b0;
    #1;
    check("async_rst_ent", entity_out, 14'h0458);
    check("async_rst_moved", {13'd0, moved}, 14'd0);
    exp_loc = 8'h58;
    exp_ori = 2'b00;
    set_btn(4'b0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1);

    do_move(4'b1001, "prio_up_left");
    check("prio_up_left_val", entity_out, 14'h0448);
    do_move(4'b0110, "prio_right_down");
    for (int i = 0; i < 5; i++) do_move(4'b1000, "up");
    for (int i = 0; i < 12; i++) do_move(4'b0010, "down");
    for (int i = 0; i < 4; i++) do_move(4'b0001, "left");
    check("at_b5", entity_out, {4'h1, 2'b11, 8'hB5});
    do_move(4'b0010, "edge_b5");
    for (int i = 0; i < 6; i++) do_move(4'b0001, "left_edge");

    set_btn(4'b0001);
    enable = 1'b0;
    exp_id = 4'hF;
    cyc(1);
    check("dis_ent", entity_out, {4'hF, exp_ori, exp_loc});
    for (int i = 0; i < 3; i++) tick(1'b0, "dis_tick");
    enable = 1'b1;
    exp_id = 4'h1;
    cyc(1);
    check("reen_id", entity_out, {4'h1, exp_ori, exp_loc});
    cyc(4);
    tick(1'b1, "reen_move");
    set_btn(4'b0000);
    cyc(3);
    tick(1'b0, "final_rel");

    check("sb_empty", 14'(exp_q.size()), 14'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
